// File: rtl/registers_bank_dump_controller_if.sv
// Byte-stream handshake between the register-bank dump sequencer and the
// downstream transmit path (byte, valid/ready and the register being sent).
interface registers_bank_dump_controller_if #(
  parameter int BYTE_SIZE   = 8,
  parameter int INDEX_WIDTH = 5
);
  logic [BYTE_SIZE-1:0]   o_byte;
  logic                   o_valid;
  logic                   i_ready;
  logic [INDEX_WIDTH-1:0] o_reg_index;

  modport master (
    output o_byte,
    output o_valid,
    output o_reg_index,
    input  i_ready
  );

  modport slave (
    input  o_byte,
    input  o_valid,
    input  o_reg_index,
    output i_ready
  );
endinterface

// File: rtl/registers_bank_dump_controller.sv
// Snapshots the flattened register-bank debug bus on a start request and
// streams every register out, register 0 first and MSB byte first.
module registers_bank_dump_controller #(
  parameter int REGISTERS_BANK_SIZE = 32,
  parameter int REGISTERS_SIZE      = 32,
  parameter int BYTE_SIZE           = 8
) (
  input  logic                                          i_clk,
  input  logic                                          i_reset,
  input  logic                                          i_start,
  input  logic [REGISTERS_BANK_SIZE*REGISTERS_SIZE-1:0] i_bus_debug,
  registers_bank_dump_controller_if.master              dump_if,
  output logic                                          o_busy,
  output logic                                          o_done
);
  localparam int BYTES_PER_REG = REGISTERS_SIZE / BYTE_SIZE;
  localparam int CNT_W = (BYTES_PER_REG > 1) ? $clog2(BYTES_PER_REG) : 1;
  localparam int IDX_W = (REGISTERS_BANK_SIZE > 1) ? $clog2(REGISTERS_BANK_SIZE) : 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES_PER_REG - 1);
  localparam logic [IDX_W-1:0] LAST_REG  = IDX_W'(REGISTERS_BANK_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DONE
  } state_t;

  state_t                    state;
  state_t                    state_next;
  logic [REGISTERS_SIZE-1:0] snapshot [REGISTERS_BANK_SIZE];
  logic [IDX_W-1:0]          reg_idx;
  logic [IDX_W-1:0]          reg_idx_next;
  logic [CNT_W-1:0]          byte_cnt;
  logic [CNT_W-1:0]          byte_cnt_next;
  logic                      capture;
  logic [REGISTERS_SIZE-1:0] cur_word;
  logic [REGISTERS_SIZE-1:0] shifted_word;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state    <= IDLE;
      reg_idx  <= '0;
      byte_cnt <= '0;
    end else begin
      state    <= state_next;
      reg_idx  <= reg_idx_next;
      byte_cnt <= byte_cnt_next;
    end
  end

  // The stream is served from this copy so the live bus may change mid-dump.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int j = 0; j < REGISTERS_BANK_SIZE; j++) begin
        snapshot[j] <= '0;
      end
    end else if (capture) begin
      for (int j = 0; j < REGISTERS_BANK_SIZE; j++) begin
        snapshot[j] <= i_bus_debug[j*REGISTERS_SIZE +: REGISTERS_SIZE];
      end
    end
  end

  // Byte 0 is the top slice, so shift the chosen word left and take its top byte.
  assign cur_word     = snapshot[reg_idx];
  assign shifted_word = cur_word << (int'(byte_cnt) * BYTE_SIZE);

  always_comb begin
    state_next          = state;
    reg_idx_next        = reg_idx;
    byte_cnt_next       = byte_cnt;
    capture             = 1'b0;
    dump_if.o_valid     = 1'b0;
    dump_if.o_byte      = '0;
    dump_if.o_reg_index = reg_idx;
    o_busy              = 1'b0;
    o_done              = 1'b0;

    case (state)
      IDLE: begin
        if (i_start) begin
          capture       = 1'b1;
          reg_idx_next  = '0;
          byte_cnt_next = '0;
          state_next    = SEND;
        end
      end

      SEND: begin
        o_busy          = 1'b1;
        dump_if.o_valid = 1'b1;
        dump_if.o_byte  = shifted_word[REGISTERS_SIZE-1 -: BYTE_SIZE];
        if (dump_if.i_ready) begin
          if (byte_cnt != LAST_BYTE) begin
            byte_cnt_next = byte_cnt + 1'b1;
          end else if (reg_idx != LAST_REG) begin
            byte_cnt_next = '0;
            reg_idx_next  = reg_idx + 1'b1;
          end else begin
            state_next = DONE;
          end
        end
      end

      DONE: begin
        o_busy        = 1'b1;
        o_done        = 1'b1;
        reg_idx_next  = '0;
        byte_cnt_next = '0;
        state_next    = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_registers_bank_dump_controller.sv
// Directed bench: per-cycle expectation tables for full dumps plus short
// hand-written sequences for reset abort and a small-parameter instance.
module tb_registers_bank_dump_controller;
  localparam int BANK = 32;
  localparam int RSZ  = 32;
  localparam int BSZ  = 8;
  localparam int IDXW = 5;

  typedef struct {
    logic       ready;
    logic       exp_valid;
    logic [7:0] exp_byte;
    logic [4:0] exp_idx;
    logic       exp_busy;
    logic       exp_done;
  } vec_t;

  logic                i_clk = 1'b0;
  logic                i_reset = 1'b0;
  logic                i_start = 1'b0;
  logic [BANK*RSZ-1:0] i_bus_debug;
  logic                o_busy;
  logic                o_done;

  logic        small_start = 1'b0;
  logic [63:0] small_bus;
  logic        small_busy;
  logic        small_done;
  logic [7:0]  small_exp [8];

  vec_t tbl [0:511];
  int   n_vec;
  int   checks = 0;
  int   passes = 0;

  registers_bank_dump_controller_if #(.BYTE_SIZE(BSZ), .INDEX_WIDTH(IDXW)) dump_if ();
  registers_bank_dump_controller_if #(.BYTE_SIZE(8), .INDEX_WIDTH(2)) small_if ();

  registers_bank_dump_controller #(
    .REGISTERS_BANK_SIZE(BANK),
    .REGISTERS_SIZE(RSZ),
    .BYTE_SIZE(BSZ)
  ) u_dut (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .i_start(i_start),
    .i_bus_debug(i_bus_debug),
    .dump_if(dump_if),
    .o_busy(o_busy),
    .o_done(o_done)
  );

  registers_bank_dump_controller #(
    .REGISTERS_BANK_SIZE(4),
    .REGISTERS_SIZE(16),
    .BYTE_SIZE(8)
  ) u_small (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .i_start(small_start),
    .i_bus_debug(small_bus),
    .dump_if(small_if),
    .o_busy(small_busy),
    .o_done(small_done)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation exceeded time budget");
    $fatal(1, "[TB] timeout");
  end

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] pattern_byte(input int j, input int k);
    case (k)
      0:       return 8'hA0;
      1:       return 8'hB0;
      2:       return 8'hC0;
      default: return 8'(j);
    endcase
  endfunction

  task automatic load_pattern();
    for (int j = 0; j < BANK; j++) begin
      i_bus_debug[j*RSZ +: RSZ] = 32'hA0B0C000 + 32'(j);
    end
  endtask

  task automatic add_vec(input logic r, input logic v, input logic [7:0] b,
                         input logic [4:0] idx, input logic busy, input logic done);
    tbl[n_vec].ready     = r;
    tbl[n_vec].exp_valid = v;
    tbl[n_vec].exp_byte  = b;
    tbl[n_vec].exp_idx   = idx;
    tbl[n_vec].exp_busy  = busy;
    tbl[n_vec].exp_done  = done;
    n_vec++;
  endtask

  // One entry per cycle after the start edge; stall_reg gets ready 1,0,0,1,0,0...
  task automatic build_table(input int stall_reg);
    int   p;
    logic r;
    n_vec = 0;
    p = 0;
    for (int j = 0; j < BANK; j++) begin
      for (int k = 0; k < 4; k++) begin
        do begin
          r = (j != stall_reg) || (p % 3 == 0);
          if (j == stall_reg) p++;
          add_vec(r, 1'b1, pattern_byte(j, k), 5'(j), 1'b1, 1'b0);
        end while (!r);
      end
    end
    add_vec(1'b1, 1'b0, 8'h00, 5'd31, 1'b1, 1'b1);
    add_vec(1'b1, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic apply_stimulus(input int start_a, input int start_b, input int hold_from,
                                input int bus_change_at, input int abort_at);
    @(negedge i_clk);
    i_start = 1'b1;
    dump_if.i_ready = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    for (int i = 0; i < n_vec; i++) begin
      check_output($sformatf("valid[%0d]", i), 32'(dump_if.o_valid), 32'(tbl[i].exp_valid));
      check_output($sformatf("byte[%0d]", i), 32'(dump_if.o_byte), 32'(tbl[i].exp_byte));
      check_output($sformatf("reg_index[%0d]", i), 32'(dump_if.o_reg_index), 32'(tbl[i].exp_idx));
      check_output($sformatf("busy[%0d]", i), 32'(o_busy), 32'(tbl[i].exp_busy));
      check_output($sformatf("done[%0d]", i), 32'(o_done), 32'(tbl[i].exp_done));
      if (i == abort_at) begin
        #2 i_reset = 1'b0;
        #1;
        check_output("abort_valid", 32'(dump_if.o_valid), 32'd0);
        check_output("abort_busy", 32'(o_busy), 32'd0);
        check_output("abort_byte", 32'(dump_if.o_byte), 32'd0);
        check_output("abort_reg_index", 32'(dump_if.o_reg_index), 32'd0);
        check_output("abort_done", 32'(o_done), 32'd0);
        repeat (3) begin
          @(negedge i_clk);
          check_output("abort_done_held", 32'(o_done), 32'd0);
          check_output("abort_valid_held", 32'(dump_if.o_valid), 32'd0);
        end
        @(negedge i_clk);
        i_reset = 1'b1;
        return;
      end
      dump_if.i_ready = tbl[i].ready;
      i_start = (i == start_a) || (i == start_b) || (hold_from >= 0 && i >= hold_from);
      if (i == bus_change_at) i_bus_debug = '1;
      @(negedge i_clk);
    end
  endtask

  initial begin
    small_exp[0] = 8'h12; small_exp[1] = 8'h34; small_exp[2] = 8'h56; small_exp[3] = 8'h78;
    small_exp[4] = 8'h9A; small_exp[5] = 8'hBC; small_exp[6] = 8'hDE; small_exp[7] = 8'hF0;
    small_bus = {16'hDEF0, 16'h9ABC, 16'h5678, 16'h1234};
    small_if.i_ready = 1'b1;
    dump_if.i_ready = 1'b1;
    load_pattern();

    @(negedge i_clk);
    check_output("reset_valid", 32'(dump_if.o_valid), 32'd0);
    check_output("reset_byte", 32'(dump_if.o_byte), 32'd0);
    check_output("reset_reg_index", 32'(dump_if.o_reg_index), 32'd0);
    check_output("reset_busy", 32'(o_busy), 32'd0);
    check_output("reset_done", 32'(o_done), 32'd0);
    i_reset = 1'b1;
    @(negedge i_clk);

    $display("[TB] full dump, ready held high");
    build_table(-1);
    apply_stimulus(-1, -1, -1, -1, -1);
    check_output("full_idle_after", 32'(o_busy), 32'd0);

    $display("[TB] backpressure during register 5");
    build_table(5);
    apply_stimulus(-1, -1, -1, -1, -1);

    $display("[TB] snapshot isolation");
    build_table(-1);
    apply_stimulus(-1, -1, -1, 0, -1);
    load_pattern();

    $display("[TB] start while busy and in DONE");
    build_table(-1);
    apply_stimulus(40, 128, -1, -1, -1);
    check_output("no_restart_valid", 32'(dump_if.o_valid), 32'd0);
    check_output("no_restart_busy", 32'(o_busy), 32'd0);

    $display("[TB] start held through DONE into IDLE");
    apply_stimulus(-1, -1, 128, -1, -1);
    check_output("held_start_valid", 32'(dump_if.o_valid), 32'd1);
    check_output("held_start_byte", 32'(dump_if.o_byte), 32'hA0);
    check_output("held_start_reg_index", 32'(dump_if.o_reg_index), 32'd0);
    i_start = 1'b0;
    #2 i_reset = 1'b0;
    @(negedge i_clk);
    i_reset = 1'b1;
    @(negedge i_clk);

    $display("[TB] reset mid-dump at byte 70, then restart");
    apply_stimulus(-1, -1, -1, -1, 70);
    @(negedge i_clk);
    apply_stimulus(-1, -1, -1, -1, -1);

    $display("[TB] small parameter variant");
    @(negedge i_clk);
    small_start = 1'b1;
    @(negedge i_clk);
    small_start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check_output($sformatf("small_valid[%0d]", k), 32'(small_if.o_valid), 32'd1);
      check_output($sformatf("small_byte[%0d]", k), 32'(small_if.o_byte), 32'(small_exp[k]));
      check_output($sformatf("small_reg_index[%0d]", k), 32'(small_if.o_reg_index), 32'(k / 2));
      @(negedge i_clk);
    end
    check_output("small_done", 32'(small_done), 32'd1);
    check_output("small_done_valid", 32'(small_if.o_valid), 32'd0);
    @(negedge i_clk);
    check_output("small_done_pulse", 32'(small_done), 32'd0);
    check_output("small_idle_busy", 32'(small_busy), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
